// File: rtl/decode_pkg.sv
// Shared decode constants: RV32 opcodes, ALU op codes and immediate kinds.
// Imported by the decode stage and its immediate generator.
package decode_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [4:0]  X0  = 5'd0;

  typedef enum logic [4:0] {
    ADDITION       = 5'd0,
    SUBTRACTION    = 5'd1,
    MULTIPLICATION = 5'd2,
    ALU_JALR       = 5'd3,
    ALU_JAL        = 5'd4,
    ALU_BEQ        = 5'd5,
    ALU_BNE        = 5'd6,
    ALU_BLT        = 5'd7,
    ALU_BGE        = 5'd8,
    ALU_BLTU       = 5'd9,
    ALU_BGEU       = 5'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_kind_e;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the RV32 immediate layout by kind and
// sign-extends it to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_kind_e       kind,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    unique case (kind)
      IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: raw = {instr[31:12], 12'b0};
      IMM_J: raw = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  assign imm = {{(XLEN-31){raw[31]}}, raw[30:0]};

endmodule

// File: rtl/decode_pipe_stage.sv
// RV32IM decode stage with valid/ready output register,
// load-use interlock and flush.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       current_program_counter,
  input  logic [XLEN-1:0]       in_passthrough_next_program_counter,
  input  logic                  kill_instr,
  output logic [REG_ADDR_W-1:0] source1_register_key,
  output logic [REG_ADDR_W-1:0] source2_register_key,
  input  logic [XLEN-1:0]       source1_register_value,
  input  logic [XLEN-1:0]       source2_register_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] operand1_key,
  output logic [REG_ADDR_W-1:0] operand2_key,
  output logic [XLEN-1:0]       operand1,
  output logic [XLEN-1:0]       operand2,
  output logic [XLEN-1:0]       store_data,
  output logic [4:0]            alu_operation,
  output logic                  dest_register_enable,
  output logic [REG_ADDR_W-1:0] dest_register_number,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  illegal_instr,
  output logic [XLEN-1:0]       branch_dest,
  output logic [XLEN-1:0]       out_passthrough_next_program_counter
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = REG_ADDR_W'(instr[11:7]);
  assign rs1    = REG_ADDR_W'(instr[19:15]);
  assign rs2    = REG_ADDR_W'(instr[24:20]);

  assign source1_register_key = rs1;
  assign source2_register_key = rs2;

  logic is_op, is_imm, is_ld, is_st, is_br;
  logic is_jalr, is_jal, is_lui, is_auipc;

  assign is_op    = opcode == OP;
  assign is_imm   = opcode == OP_IMM;
  assign is_ld    = opcode == LOAD;
  assign is_st    = opcode == STORE;
  assign is_br    = opcode == BRANCH;
  assign is_jalr  = opcode == JALR;
  assign is_jal   = opcode == JAL;
  assign is_lui   = opcode == LUI;
  assign is_auipc = opcode == AUIPC;

  imm_kind_e       kind;
  logic [XLEN-1:0] imm;

  always_comb begin
    kind = IMM_I;
    unique case (1'b1)
      is_st:            kind = IMM_S;
      is_br:            kind = IMM_B;
      is_lui, is_auipc: kind = IMM_U;
      is_jal:           kind = IMM_J;
      default:          kind = IMM_I;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr[31:7]),
    .kind  (kind),
    .imm   (imm)
  );

  logic [XLEN-1:0] d_op1, d_op2, d_sd, d_bd;
  alu_op_e         d_alu;
  logic            d_wr, d_ld, d_st, d_ill, d_den;
  logic [REG_ADDR_W-1:0] d_rd;
  logic op_add, op_sub, op_mul, ld_ok;

  assign op_add = funct3 == 3'd0 && funct7 == 7'h00;
  assign op_sub = funct3 == 3'd0 && funct7 == 7'h20;
  assign op_mul = ENABLE_MUL && funct3 == 3'd0 && funct7 == 7'h01;
  assign ld_ok  = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always_comb begin
    d_op1 = source1_register_value;
    d_op2 = '0;
    d_sd  = '0;
    d_bd  = '0;
    d_alu = ADDITION;
    d_wr  = 1'b0;
    d_ld  = 1'b0;
    d_st  = 1'b0;
    d_ill = 1'b0;
    unique case (1'b1)
      is_op: begin
        d_op2 = source2_register_value;
        d_wr  = 1'b1;
        unique case (1'b1)
          op_add:  d_alu = ADDITION;
          op_sub:  d_alu = SUBTRACTION;
          op_mul:  d_alu = MULTIPLICATION;
          default: d_ill = 1'b1;
        endcase
      end
      is_imm: begin
        d_op2 = imm;
        d_wr  = 1'b1;
        d_ill = funct3 != 3'd0;
      end
      is_ld: begin
        d_op2 = imm;
        d_wr  = 1'b1;
        d_ld  = 1'b1;
        d_ill = !ld_ok;
      end
      is_st: begin
        d_op2 = imm;
        d_sd  = source2_register_value;
        d_st  = 1'b1;
        d_ill = funct3 > 3'd2;
      end
      is_br: begin
        d_op2 = source2_register_value;
        d_bd  = current_program_counter + imm;
        unique case (funct3)
          3'd0:    d_alu = ALU_BEQ;
          3'd1:    d_alu = ALU_BNE;
          3'd4:    d_alu = ALU_BLT;
          3'd5:    d_alu = ALU_BGE;
          3'd6:    d_alu = ALU_BLTU;
          3'd7:    d_alu = ALU_BGEU;
          default: d_ill = 1'b1;
        endcase
      end
      is_jalr: begin
        d_op2 = imm;
        d_alu = ALU_JALR;
        d_wr  = 1'b1;
        d_ill = funct3 != 3'd0;
      end
      is_jal: begin
        d_op1 = current_program_counter;
        d_op2 = XLEN'(4);
        d_alu = ALU_JAL;
        d_wr  = 1'b1;
        d_bd  = current_program_counter + imm;
      end
      is_lui: begin
        d_op1 = '0;
        d_op2 = imm;
        d_wr  = 1'b1;
      end
      is_auipc: begin
        d_op1 = current_program_counter;
        d_op2 = imm;
        d_wr  = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // an illegal word must not look like any real class downstream
    if (d_ill) begin
      d_alu = ADDITION;
      d_wr  = 1'b0;
      d_ld  = 1'b0;
      d_st  = 1'b0;
      d_sd  = '0;
      d_bd  = '0;
    end
  end

  assign d_den = d_wr && rd != '0;
  assign d_rd  = d_den ? rd : REG_ADDR_W'(X0);

  logic uses1, uses2, hazard, advance;

  assign uses1 = !(is_lui || is_auipc || is_jal);
  assign uses2 = is_op || is_br || is_st;

  assign hazard = in_valid && out_valid && is_load
               && dest_register_enable
               && ((uses1 && rs1 == dest_register_number)
                || (uses2 && rs2 == dest_register_number));

  assign advance  = !out_valid || out_ready;
  assign in_ready = kill_instr || (advance && !hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid            <= 1'b0;
      operand1_key         <= '0;
      operand2_key         <= '0;
      operand1             <= '0;
      operand2             <= '0;
      store_data           <= '0;
      alu_operation        <= ADDITION;
      dest_register_enable <= 1'b0;
      dest_register_number <= REG_ADDR_W'(X0);
      is_load              <= 1'b0;
      is_store             <= 1'b0;
      illegal_instr        <= 1'b0;
      branch_dest          <= '0;
      out_passthrough_next_program_counter <= '0;
    end else if (kill_instr) begin
      out_valid            <= 1'b0;
      dest_register_enable <= 1'b0;
    end else if (advance) begin
      out_valid            <= in_valid && !hazard;
      operand1_key         <= rs1;
      operand2_key         <= rs2;
      operand1             <= d_op1;
      operand2             <= d_op2;
      store_data           <= d_sd;
      alu_operation        <= d_alu;
      dest_register_enable <= d_den && in_valid && !hazard;
      dest_register_number <= d_rd;
      is_load              <= d_ld;
      is_store             <= d_st;
      illegal_instr        <= d_ill;
      branch_dest          <= d_bd;
      out_passthrough_next_program_counter <=
        in_passthrough_next_program_counter;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: directed RV32 words with
// hand-computed decode results, checked by an output monitor.
module tb_decode_pipe_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = NOP;
  logic [31:0] cur_pc = '0;
  logic [31:0] nxt_pc = '0;
  logic        kill_instr = 1'b0;
  logic [4:0]  src1_key, src2_key;
  logic [31:0] src1_val, src2_val;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  op1_key, op2_key;
  logic [31:0] operand1, operand2, store_data;
  logic [4:0]  alu_operation;
  logic        dest_en;
  logic [4:0]  dest_num;
  logic        is_load, is_store, illegal_instr;
  logic [31:0] branch_dest, out_npc;

  logic [31:0] rf [32];

  assign src1_val = rf[src1_key];
  assign src2_val = rf[src2_key];

  always #5 clk = ~clk;

  decode_pipe_stage #(
    .XLEN(32), .REG_ADDR_W(5), .ENABLE_MUL(1'b1)
  ) dut (
    .clk                                  (clk),
    .reset                                (reset),
    .in_valid                             (in_valid),
    .in_ready                             (in_ready),
    .instr                                (instr),
    .current_program_counter              (cur_pc),
    .in_passthrough_next_program_counter  (nxt_pc),
    .kill_instr                           (kill_instr),
    .source1_register_key                 (src1_key),
    .source2_register_key                 (src2_key),
    .source1_register_value               (src1_val),
    .source2_register_value               (src2_val),
    .out_valid                            (out_valid),
    .out_ready                            (out_ready),
    .operand1_key                         (op1_key),
    .operand2_key                         (op2_key),
    .operand1                             (operand1),
    .operand2                             (operand2),
    .store_data                           (store_data),
    .alu_operation                        (alu_operation),
    .dest_register_enable                 (dest_en),
    .dest_register_number                 (dest_num),
    .is_load                              (is_load),
    .is_store                             (is_store),
    .illegal_instr                        (illegal_instr),
    .branch_dest                          (branch_dest),
    .out_passthrough_next_program_counter (out_npc)
  );

  typedef struct packed {
    logic        cops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [31:0] bd;
    logic [31:0] npc;
    logic [4:0]  alu;
    logic        den;
    logic [4:0]  rd;
    logic        ld;
    logic        st;
    logic        ill;
  } exp_t;

  exp_t  sb [$];
  string nq [$];
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t mk(
    logic [31:0] op1, logic [31:0] op2, logic [31:0] sd,
    logic [31:0] bd, logic [31:0] npc, logic [4:0] alu,
    logic den, logic [4:0] rd, logic ld, logic st,
    logic ill, logic cops);
    exp_t e;
    e.cops = cops; e.op1 = op1; e.op2 = op2; e.sd = sd;
    e.bd = bd; e.npc = npc; e.alu = alu; e.den = den;
    e.rd = rd; e.ld = ld; e.st = st; e.ill = ill;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: every transfer to execute is matched against the queue
  exp_t  me;
  string mn;
  logic  ok;
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got alu=%0d rd=%0d, required none",
                 alu_operation, dest_num);
      end else begin
        me = sb.pop_front();
        mn = nq.pop_front();
        ok = alu_operation === me.alu && dest_en === me.den
          && dest_num === me.rd && is_load === me.ld
          && is_store === me.st && illegal_instr === me.ill;
        if (me.cops)
          ok = ok && operand1 === me.op1 && operand2 === me.op2
            && store_data === me.sd && branch_dest === me.bd
            && out_npc === me.npc;
        if (!ok) begin
          errors++;
          $display({"FAIL %s: got op1=%h op2=%h sd=%h bd=%h npc=%h alu=%0d ",
                    "den=%0b rd=%0d ld=%0b st=%0b ill=%0b required op1=%h ",
                    "op2=%h sd=%h bd=%h npc=%h alu=%0d den=%0b rd=%0d ",
                    "ld=%0b st=%0b ill=%0b"},
                   mn, operand1, operand2, store_data, branch_dest, out_npc,
                   alu_operation, dest_en, dest_num, is_load, is_store,
                   illegal_instr, me.op1, me.op2, me.sd, me.bd, me.npc,
                   me.alu, me.den, me.rd, me.ld, me.st, me.ill);
        end
      end
    end
  end

  // Present one word and hold it until accepted; returns at edge+1.
  task automatic issue(string nm, logic [31:0] w, logic [31:0] pc,
                       exp_t e, output int stalls);
    in_valid = 1'b1;
    instr    = w;
    cur_pc   = pc;
    nxt_pc   = pc + 32'd4;
    #1;
    stalls = 0;
    while (!in_ready && stalls < 20) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready got 0 required 1", nm);
    end else begin
      sb.push_back(e);
      nq.push_back(nm);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] W_ADDI  = 32'hFFD0_8293;
  localparam logic [31:0] W_LW    = 32'h0001_2303;
  localparam logic [31:0] W_ADD   = 32'h0013_03B3;
  localparam logic [31:0] W_SW    = 32'h0081_2623;
  localparam logic [31:0] W_ADDI9 = 32'h0011_8493;
  localparam logic [31:0] W_BEQ   = 32'hFE20_8CE3;
  localparam logic [31:0] W_BNE   = 32'hFE20_9CE3;
  localparam logic [31:0] W_JAL   = 32'h0080_00EF;
  localparam logic [31:0] W_LUI   = 32'h1234_5537;
  localparam logic [31:0] W_MUL   = 32'h0230_85B3;
  localparam logic [31:0] W_SUB   = 32'h4011_8633;
  localparam logic [31:0] W_ILL   = 32'h0000_007F;

  initial begin
    #100000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd10;
    rf[2] = 32'h1000;
    rf[3] = 32'h55;
    rf[6] = 32'h77;
    rf[8] = 32'hDEADBEEF;

    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_alu", {27'b0, alu_operation}, 0);
    chk("rst_dest_num", {27'b0, dest_num}, 0);
    chk("rst_operand1", operand1, 0);
    chk("rst_branch_dest", branch_dest, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset while a live instruction is held
    out_ready = 1'b0;
    issue("lui_pre", W_LUI, 32'h10,
          mk(0, 32'h12345000, 0, 0, 32'h14, ADDITION, 1, 10, 0, 0, 0, 1), st);
    in_valid = 1'b0;
    chk("held_valid", {31'b0, out_valid}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_operand2", operand2, 0);
    chk("mid_rst_dest_en", {31'b0, dest_en}, 0);
    chk("mid_rst_dest_num", {27'b0, dest_num}, 0);
    chk("mid_rst_npc", out_npc, 0);
    sb.delete();
    nq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;

    issue("addi", W_ADDI, 32'h40,
          mk(10, 32'hFFFFFFFD, 0, 0, 32'h44, ADDITION, 1, 5, 0, 0, 0, 1), st);
    issue("lui", W_LUI, 32'h44,
          mk(0, 32'h12345000, 0, 0, 32'h48, ADDITION, 1, 10, 0, 0, 0, 1), st);
    issue("sub", W_SUB, 32'h48,
          mk(32'h55, 10, 0, 0, 32'h4C, SUBTRACTION, 1, 12, 0, 0, 0, 1), st);
    issue("mul", W_MUL, 32'h4C,
          mk(10, 32'h55, 0, 0, 32'h50, MULTIPLICATION, 1, 11, 0, 0, 0, 1), st);
    issue("beq", W_BEQ, 32'h100,
          mk(10, 32'h1000, 0, 32'hF8, 32'h104, ALU_BEQ, 0, 0, 0, 0, 0, 1), st);
    issue("bne", W_BNE, 32'h200,
          mk(10, 32'h1000, 0, 32'h1F8, 32'h204, ALU_BNE, 0, 0, 0, 0, 0, 1), st);
    issue("jal_wrap", W_JAL, 32'hFFFFFFFC,
          mk(32'hFFFFFFFC, 4, 0, 32'h4, 32'h0, ALU_JAL, 1, 1, 0, 0, 0, 1), st);
    issue("nop", NOP, 32'h300,
          mk(0, 0, 0, 0, 32'h304, ADDITION, 0, 0, 0, 0, 0, 1), st);
    issue("illegal", W_ILL, 32'h304,
          mk(0, 0, 0, 0, 0, ADDITION, 0, 0, 0, 0, 1, 0), st);
    idle();

    // load-use: exactly one bubble
    issue("lw", W_LW, 32'h44,
          mk(32'h1000, 0, 0, 0, 32'h48, ADDITION, 1, 6, 1, 0, 0, 1), st);
    in_valid = 1'b1;
    instr    = W_ADD;
    cur_pc   = 32'h48;
    nxt_pc   = 32'h4C;
    #1;
    chk("hazard_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk); #1;
    chk("bubble_valid", {31'b0, out_valid}, 0);
    chk("post_bubble_in_ready", {31'b0, in_ready}, 1);
    issue("add_after_lw", W_ADD, 32'h48,
          mk(32'h77, 10, 0, 0, 32'h4C, ADDITION, 1, 7, 0, 0, 0, 1), st);
    chk("add_extra_stalls", st, 0);
    idle();

    // execute back-pressure holding a store
    out_ready = 1'b0;
    issue("sw", W_SW, 32'h50,
          mk(32'h1000, 12, 32'hDEADBEEF, 0, 32'h54, ADDITION,
             0, 0, 0, 1, 0, 1), st);
    in_valid = 1'b1;
    instr    = W_ADDI9;
    cur_pc   = 32'h54;
    nxt_pc   = 32'h58;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'b0, in_ready}, 0);
      chk("stall_valid", {31'b0, out_valid}, 1);
      chk("stall_store_data", store_data, 32'hDEADBEEF);
      chk("stall_operand2", operand2, 32'd12);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue("addi_after_stall", W_ADDI9, 32'h54,
          mk(32'h55, 1, 0, 0, 32'h58, ADDITION, 1, 9, 0, 0, 0, 1), st);
    chk("stall_release_wait", st, 0);
    idle();

    // flush during a load-use stall
    issue("lw_k", W_LW, 32'h60,
          mk(32'h1000, 0, 0, 0, 32'h64, ADDITION, 1, 6, 1, 0, 0, 1), st);
    in_valid   = 1'b1;
    instr      = W_ADD;
    cur_pc     = 32'h64;
    nxt_pc     = 32'h68;
    kill_instr = 1'b1;
    #1;
    chk("kill_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    chk("kill_valid", {31'b0, out_valid}, 0);
    kill_instr = 1'b0;
    in_valid   = 1'b0;
    @(posedge clk); #1;
    chk("kill_still_empty", {31'b0, out_valid}, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised RV32IM decode stage with a valid/ready pipeline register, load-use interlock and flush. It sits between fetch and execute. It reads the register file through combinational key/value ports, produces ALU operands, store data and branch/jump targets, and stalls upstream when the instruction it holds cannot advance. It replaces the fixed-width, always-advancing decode stage and adds U/J-type decode, store-data forwarding and illegal-opcode flagging.

## Interface
- XLEN, 32: datapath width; immediates sign-extended to XLEN.
- REG_ADDR_W, 5: register key width.
- ENABLE_MUL, 1: 1 decodes MUL (funct7 0x01); 0 flags it illegal.
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  instr/pc/next_pc valid.
- in_ready  out  1  stage accepts input this cycle.
- instr  in  32  instruction word.
- current_program_counter, in_passthrough_next_program_counter  in  XLEN  PC of instr, PC+4.
- kill_instr  in  1  flush: discard input and held instruction.
- source1_register_key, source2_register_key  out  REG_ADDR_W  rs1/rs2, combinational from instr.
- source1_register_value, source2_register_value  in  XLEN  register file read data, same cycle.
- out_valid  out  1  registered outputs hold a live instruction.
- out_ready  in  1  execute accepts the held instruction.
- operand1_key, operand2_key  out  REG_ADDR_W  registered rs1/rs2 (forwarding).
- operand1, operand2  out  XLEN  ALU operands.
- store_data  out  XLEN  rs2 value for STORE, else 0.
- alu_operation  out  5  ALU op code.
- dest_register_enable  out  1; dest_register_number  out  REG_ADDR_W.
- is_load, is_store, illegal_instr  out  1  registered class flags.
- branch_dest  out  XLEN  pc + B-imm (BRANCH) or pc + J-imm (JAL), else 0.
- out_passthrough_next_program_counter  out  XLEN.

## Operation
- Decode: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- operand1: rs1 value; LUI -> 0; AUIPC, JAL -> pc.
- operand2: OP, BRANCH -> rs2 value; OP_IMM, LOAD, JALR -> sext(I); STORE -> sext(S); LUI, AUIPC -> {instr[31:12], 12'b0}; JAL -> 4.
- alu_operation: ADD/ADDI/LOAD/STORE/LUI/AUIPC -> ADDITION; SUB -> SUBTRACTION; MUL -> MULTIPLICATION; JALR -> ALU_JALR; JAL -> ALU_JAL; BEQ/BLT/BGE/BLTU/BGEU -> matching ALU_B*; BNE -> ALU_BNE.
- Destination enable = 1 for OP, OP_IMM, LOAD, JALR, JAL, LUI, AUIPC with rd != x0; otherwise enable = 0 and number = x0.
- Any other opcode/funct combination: illegal_instr = 1, dest enable 0, alu_operation ADDITION, is_load/is_store 0.
- Arithmetic is modulo 2^XLEN; PC wrap-around is silent.
- Load-use hazard: `out_valid && is_load && dest_register_enable` is held, and in_valid is high. The incoming instruction uses source1 (all opcodes except LUI, AUIPC, JAL) or source2 (OP, BRANCH, STORE) whose key equals the held dest_register_number. The hazard then holds in_ready low and, if out_ready is high, loads a bubble (out_valid = 0).

## Timing
- Latency 1 cycle: the instruction accepted at edge N appears on the outputs after edge N.
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard, or 1 when kill_instr is high.
- On each edge:
  - kill_instr high: out_valid <= 0; input discarded regardless of in_valid/out_ready. Kill has priority over hazard and acceptance.
  - Else if advance: out_valid <= in_valid && !hazard; the data registers load the decoded input (bubble contents don't care, but dest enable is forced 0).
  - Else: all outputs hold.
- When stalled, outputs stay stable while out_valid && !out_ready (execute handshake rule). The register file values must be re-read every cycle.
- Hazard bubble costs exactly one cycle: the next cycle out_valid = 0, the hazard clears and the instruction is accepted.
- Reset (asynchronous, mid-operation included) clears:
  - out_valid, all flags, operands, store_data, keys, branch_dest and passthrough PC to 0;
  - alu_operation to ADDITION and dest_register_number to x0.
  - in_ready is 1 after reset.

## Structure
- Package decode_pkg holds:
  - opcode constants OP, OP_IMM, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, plus NOP and x0;
  - ALU op codes, including new ALU_JAL and ALU_BNE;
  - an imm_kind enum (I, S, B, U, J).
- Sub-module imm_gen: combinational, instr and imm_kind -> sign-extended XLEN immediate.
- The top level holds the decode, hazard logic and output register.

## Test plan
- Reset mid-stream with out_valid = 1 -> outputs go to reset values immediately, without waiting for a clock edge; first instruction after release decodes normally.
- ADDI x5, x1, -3 with x1 = 10 -> one cycle later: operand1 = 10, operand2 = 0xFFFFFFFD, ADDITION, dest enable 1, rd 5.
- LW x6, 0(x2) followed by ADD x7, x6, x1 -> one bubble with in_ready = 0; ADD valid two cycles after LW.
- out_ready low for 3 cycles holding a SW -> outputs stable and in_ready 0 throughout; SW store_data = rs2 value.
- BEQ at pc 0x100 with B-imm -8 -> branch_dest 0xF8. JAL at pc 0xFFFFFFFC with imm 8 -> branch_dest 0x4 (wrap).
- kill_instr with in_valid = 1 during a hazard stall -> out_valid 0 next cycle, input consumed. Opcode 0x7F -> illegal_instr 1 and dest enable 0.
